// File: rtl/dt_pkg.sv
// rtl/dt_pkg.sv - shared distance-transform constants, address packing, FSM states, neighbour table
// Build macro DT_RIDGE_8N_EN: ridge scan reads all 8 neighbours instead of 4.
package dt_pkg;

  localparam int IMG_W   = 128;
  localparam int WORD_W  = 16;
  localparam int DIST_W  = 8;
  localparam int COORD_W = 7;
  localparam int WORD_SH = $clog2(WORD_W);
  localparam int PIX_AW  = 2 * COORD_W;
  localparam int WORD_AW = 2 * COORD_W - WORD_SH;

`ifdef DT_RIDGE_8N_EN
  localparam int NUM_NB = 9;
`else
  localparam int NUM_NB = 5;
`endif

  typedef enum logic [2:0] {IDLE, RD, EV, WR, FINISH} dt_state_e;

  function automatic logic [PIX_AW-1:0] pix_addr(input logic [COORD_W-1:0] row,
                                                  input logic [COORD_W-1:0] col);
    return {row, col};
  endfunction

  function automatic logic [WORD_AW-1:0] word_addr(input logic [COORD_W-1:0] row,
                                                    input logic [COORD_W-1:0] col);
    return {row, col[COORD_W-1:WORD_SH]};
  endfunction

  // Read order C,N,S,W,E,NW,NE,SW,SE; result is {drow, dcol}, each 2-bit two's complement.
  function automatic logic [3:0] nb_offset(input logic [3:0] idx);
    case (idx)
      4'd1:    return {2'b11, 2'b00};
      4'd2:    return {2'b01, 2'b00};
      4'd3:    return {2'b00, 2'b11};
      4'd4:    return {2'b00, 2'b01};
      4'd5:    return {2'b11, 2'b11};
      4'd6:    return {2'b11, 2'b01};
      4'd7:    return {2'b01, 2'b11};
      4'd8:    return {2'b01, 2'b01};
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dt_bit_packer.sv
// rtl/dt_bit_packer.sv - MSB-first skeleton bit packer; flags the bit that completes a word
module dt_bit_packer
  import dt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              bit_en,
  input  logic              bit_in,
  output logic [WORD_W-1:0] word,
  output logic              word_last
);

  logic [WORD_SH-1:0] bit_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word    <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      word    <= '0;
      bit_cnt <= '0;
    end else if (bit_en) begin
      word    <= {word[WORD_W-2:0], bit_in};
      bit_cnt <= bit_cnt + WORD_SH'(1);
    end
  end

  // High while the next strobed bit is the rightmost pixel of the word.
  assign word_last = (bit_cnt == WORD_SH'(WORD_W - 1));

endmodule

// File: rtl/dt_ridge_extract.sv
// rtl/dt_ridge_extract.sv - marks nonzero local maxima of the DT map as a packed skeleton image
// Build macro DT_RIDGE_8N_EN: 8-neighbour ridge rule (default 4-neighbour).
module dt_ridge_extract
  import dt_pkg::*;
#(
  parameter int IMG_W = dt_pkg::IMG_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               dist_rd,
  output logic [PIX_AW-1:0]  dist_addr,
  input  logic [DIST_W-1:0]  dist_di,
  output logic               sk_wr,
  output logic [WORD_AW-1:0] sk_addr,
  output logic [WORD_W-1:0]  sk_do,
  output logic [DIST_W-1:0]  max_dist,
  output logic [PIX_AW-1:0]  sk_count
);

  localparam logic [COORD_W-1:0] LAST   = COORD_W'(IMG_W - 1);
  localparam logic [PIX_AW-1:0]  SK_MAX = '1;

  dt_state_e           state, state_nxt;
  logic [COORD_W-1:0]  row, col, row_nxt, col_nxt;
  logic [COORD_W-1:0]  rd_row, rd_col;
  logic [3:0]          cnt;
  logic [3:0]          ofs;
  logic [DIST_W-1:0]   cen;
  logic                ok;
  logic [PIX_AW-1:0]   addr_hold;
  logic                border, border_nxt, last_pix, ridge_bit, word_last, accept;

  assign accept   = start && (state == IDLE || state == FINISH);
  assign border   = (row == '0) || (row == LAST) || (col == '0) || (col == LAST);
  assign last_pix = (row == LAST) && (col == LAST);

  always_comb begin
    row_nxt = row;
    col_nxt = col + COORD_W'(1);
    if (col == LAST) begin
      col_nxt = '0;
      row_nxt = row + COORD_W'(1);
    end
  end

  assign border_nxt = (row_nxt == '0) || (row_nxt == LAST) || (col_nxt == '0) || (col_nxt == LAST);
  // In EV the last neighbour's data is on dist_di; border pixels always pack a 0.
  assign ridge_bit  = !border && ok && (cen >= dist_di);

  assign ofs    = nb_offset(cnt);
  assign rd_row = row + {{(COORD_W-2){ofs[3]}}, ofs[3:2]};
  assign rd_col = col + {{(COORD_W-2){ofs[1]}}, ofs[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FINISH: if (start) state_nxt = EV;   // pixel (0,0) is a border pixel
      RD:           if (cnt == 4'(NUM_NB - 1)) state_nxt = EV;
      EV:           state_nxt = word_last ? WR : (border_nxt ? EV : RD);
      WR:           state_nxt = last_pix ? FINISH : (border_nxt ? EV : RD);
      default:      state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == RD) || (state == EV) || (state == WR);
    done      = (state == FINISH);
    dist_rd   = (state == RD);
    sk_wr     = (state == WR);
    dist_addr = (state == RD) ? pix_addr(rd_row, rd_col) : addr_hold;
    sk_addr   = word_addr(row, col);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row       <= '0;
      col       <= '0;
      cnt       <= '0;
      cen       <= '0;
      ok        <= 1'b0;
      addr_hold <= '0;
      max_dist  <= '0;
      sk_count  <= '0;
    end else begin
      addr_hold <= dist_addr;
      case (state)
        IDLE, FINISH: begin
          if (start) begin
            row      <= '0;
            col      <= '0;
            cnt      <= '0;
            max_dist <= '0;
            sk_count <= '0;
          end
        end
        RD: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'd1) begin
            cen <= dist_di;
            ok  <= (dist_di != '0);
            if (dist_di > max_dist) max_dist <= dist_di;
          end else if (cnt > 4'd1) begin
            ok <= ok && (cen >= dist_di);
          end
        end
        EV: begin
          cnt <= '0;
          if (ridge_bit && sk_count != SK_MAX) sk_count <= sk_count + PIX_AW'(1);
          if (!word_last) begin
            row <= row_nxt;
            col <= col_nxt;
          end
        end
        WR: begin
          cnt <= '0;
          row <= row_nxt;
          col <= col_nxt;
        end
        default: ;
      endcase
    end
  end

  dt_bit_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .bit_en    (state == EV),
    .bit_in    (ridge_bit),
    .word      (sk_do),
    .word_last (word_last)
  );

endmodule

// File: tb/tb_dt_ridge_extract.sv
// tb/tb_dt_ridge_extract.sv - scoreboard bench for dt_ridge_extract on a 16x16 scan window
`timescale 1ns/1ps
module tb_dt_ridge_extract;

  localparam int W = 16;
`ifdef DT_RIDGE_8N_EN
  localparam int NRD = 9;
`else
  localparam int NRD = 5;
`endif
  localparam int EXP_CYC = (W-2)*(W-2)*(NRD+1) + 4*(W-1) + W*W/16;
  localparam int EXP_RDS = (W-2)*(W-2)*NRD;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, dist_rd, sk_wr;
  logic [13:0] dist_addr;
  logic [7:0]  dist_di = 8'd0;
  logic [9:0]  sk_addr;
  logic [15:0] sk_do;
  logic [7:0]  max_dist;
  logic [13:0] sk_count;

  logic [7:0]  mem [0:16383];

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  rd_cnt = 0;
  int  exp_count;
  int  exp_max;

  always #5 clk = ~clk;

  dt_ridge_extract #(.IMG_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .dist_rd   (dist_rd),
    .dist_addr (dist_addr),
    .dist_di   (dist_di),
    .sk_wr     (sk_wr),
    .sk_addr   (sk_addr),
    .sk_do     (sk_do),
    .max_dist  (max_dist),
    .sk_count  (sk_count)
  );

  always @(posedge clk) begin
    if (dist_rd) begin
      dist_di <= mem[dist_addr];
      rd_cnt  <= rd_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (reset && sk_wr) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got write to 0x%0h, expected no write", sk_addr);
      end else begin
        e = exp_q.pop_front();
        check("sk_addr", 32'(sk_addr), 32'(e.addr));
        check("sk_do", 32'(sk_do), 32'(e.data));
      end
    end
  end

  function automatic int px(input int r, input int c);
    return int'(mem[r*128 + c]);
  endfunction

  task automatic build_expected();
    logic [15:0] w;
    int c, v;
    bit rid;
    exp_q.delete();
    exp_count = 0;
    exp_max   = 0;
    for (int r = 0; r < W; r++) begin
      for (int wi = 0; wi < W/16; wi++) begin
        w = '0;
        for (int k = 0; k < 16; k++) begin
          c   = wi*16 + k;
          rid = 1'b0;
          if (r > 0 && r < W-1 && c > 0 && c < W-1) begin
            v = px(r, c);
            if (v > exp_max) exp_max = v;
            rid = (v != 0) && v >= px(r-1, c) && v >= px(r+1, c) &&
                  v >= px(r, c-1) && v >= px(r, c+1);
`ifdef DT_RIDGE_8N_EN
            rid = rid && v >= px(r-1, c-1) && v >= px(r-1, c+1) &&
                  v >= px(r+1, c-1) && v >= px(r+1, c+1);
`endif
          end
          if (rid) begin
            w[15-k] = 1'b1;
            exp_count++;
          end
        end
        exp_q.push_back('{addr: 10'(r*8 + wi), data: w});
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16384; i++) mem[i] = 8'd0;
  endtask

  task automatic random_mem();
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++)
        mem[r*128 + c] = 8'($urandom_range(0, 4));
  endtask

  task automatic run_scan(input string name, input bit mid_start);
    int n;
    int rd_base;
    n = 0;
    build_expected();
    rd_base = rd_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy_after_start"}, 32'(busy), 32'd1);
    while (!done && n < EXP_CYC + 100) begin
      @(posedge clk);
      #1;
      n++;
      if (mid_start && n == 300) start = 1'b1;
      if (mid_start && n == 301) start = 1'b0;
    end
    check({name, "_cycles"}, 32'(n), 32'(EXP_CYC));
    check({name, "_busy_at_done"}, 32'(busy), 32'd0);
    check({name, "_sk_count"}, 32'(sk_count), 32'(exp_count));
    check({name, "_max_dist"}, 32'(max_dist), 32'(exp_max));
    check({name, "_words_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_reads"}, 32'(rd_cnt - rd_base), 32'(EXP_RDS));
  endtask

  initial begin
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dist_rd", 32'(dist_rd), 32'd0);
    check("rst_dist_addr", 32'(dist_addr), 32'd0);
    check("rst_sk_wr", 32'(sk_wr), 32'd0);
    check("rst_sk_addr", 32'(sk_addr), 32'd0);
    check("rst_sk_do", 32'(sk_do), 32'd0);
    check("rst_max_dist", 32'(max_dist), 32'd0);
    check("rst_sk_count", 32'(sk_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_scan("zero", 1'b0);
    check("zero_count_const", 32'(sk_count), 32'd0);

    mem[5*128 + 5] = 8'd3;
    run_scan("single", 1'b0);
    check("single_count_const", 32'(sk_count), 32'd1);
    check("single_max_const", 32'(max_dist), 32'd3);

    clear_mem();
    for (int r = 10; r <= 12; r++)
      for (int c = 10; c <= 12; c++)
        mem[r*128 + c] = 8'd2;
    run_scan("plateau", 1'b0);
    check("plateau_count_const", 32'(sk_count), 32'd9);

    clear_mem();
    mem[1*128 + 1] = 8'd1;
    run_scan("corner", 1'b0);
    check("corner_count_const", 32'(sk_count), 32'd1);

    clear_mem();
    mem[6*128 + 6] = 8'd3;
    mem[7*128 + 7] = 8'd2;
    run_scan("diag", 1'b0);
`ifdef DT_RIDGE_8N_EN
    check("diag_count_const", 32'(sk_count), 32'd1);
`else
    check("diag_count_const", 32'(sk_count), 32'd2);
`endif

    random_mem();
    run_scan("rand0", 1'b0);
    random_mem();
    run_scan("rand_busy_start", 1'b1);

    random_mem();
    build_expected();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (500) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_sk_wr", 32'(sk_wr), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_dist_rd", 32'(dist_rd), 32'd0);
    check("abort_sk_count", 32'(sk_count), 32'd0);
    check("abort_sk_do", 32'(sk_do), 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_scan("after_reset", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
